// File: rtl/fx_writeback_stage.sv
// Result-evaluation stage of the fixed-point pipe: selects the writeback word,
// derives CR0, maintains XER and buffers results in a 2-entry in-order FIFO.
module fx_writeback_stage #(
  parameter int regWidth   = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                inValid_i,
  output logic                inReady_o,
  input  logic [127:0]        result_i,
  input  logic                selHigh_i,
  input  logic                isMul_i,
  input  logic                is64Bit_i,
  input  logic                carry_i,
  input  logic                carry32_i,
  input  logic                ov_i,
  input  logic                ov32_i,
  input  logic                updateCA_i,
  input  logic                updateOV_i,
  input  logic                recordCR0_i,
  input  logic [regWidth-1:0] regAddress_i,
  input  logic                xerWrite_i,
  input  logic [63:0]         xerData_i,
  output logic                wbValid_o,
  input  logic                wbReady_i,
  output logic [63:0]         wbData_o,
  output logic [regWidth-1:0] wbAddress_o,
  output logic                cr0Valid_o,
  output logic [3:0]          cr0_o,
  output logic [63:0]         xer_o
);

  // XER fields in big-endian bit numbering (bit 0 = MSB) map to vector bit 63-n.
  localparam int XER_SO   = 63 - 32;
  localparam int XER_OV   = 63 - 33;
  localparam int XER_CA   = 63 - 34;
  localparam int XER_OV32 = 63 - 44;
  localparam int XER_CA32 = 63 - 45;

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  typedef struct packed {
    logic [63:0]         data;
    logic [regWidth-1:0] addr;
    logic                cr0_valid;
    logic [3:0]          cr0;
  } wb_entry_t;

  wb_entry_t   mem [2];
  wb_entry_t   new_entry;
  wb_entry_t   head;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        full, empty, push, pop;
  logic [63:0] xer_q, xer_next;

  // Result fields: big-endian [0:63] is the high dword, [64:127] the low dword.
  logic [63:0] hi_dword, lo_dword, w, cmp;
  logic        mul_ov64, mul_ov32, ov_new, ov32_new, ca_new, so_new;
  logic        lt, gt, eq;
  logic        unused_xer_bits;

  assign unused_xer_bits = ^{xerData_i[63:32], xerData_i[30], xerData_i[28:20],
                             xerData_i[17:0]};

  assign full      = (count == DEPTH);
  assign empty     = (count == 2'd0);
  assign inReady_o = reset_i & ~full & ~xerWrite_i;
  assign push      = inValid_i & inReady_o;
  assign pop       = ~empty & wbReady_i;

  assign hi_dword = result_i[127:64];
  assign lo_dword = result_i[63:0];
  assign w        = selHigh_i ? hi_dword : lo_dword;

  // Product overflow: high part must be the sign extension of the kept part.
  assign mul_ov64 = hi_dword != {64{lo_dword[63]}};
  assign mul_ov32 = lo_dword[63:32] != {32{lo_dword[31]}};
  assign ov32_new = isMul_i ? mul_ov32 : ov32_i;
  assign ov_new   = isMul_i ? (is64Bit_i ? mul_ov64 : mul_ov32)
                            : (is64Bit_i ? ov_i : ov32_i);
  assign ca_new   = is64Bit_i ? carry_i : carry32_i;
  assign so_new   = xer_q[XER_SO] | (updateOV_i & ov_new);

  assign cmp = is64Bit_i ? w : {{32{w[31]}}, w[31:0]};
  assign lt  = cmp[63];
  assign eq  = (cmp == 64'd0);
  assign gt  = ~lt & ~eq;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    new_entry           = '0;
    new_entry.data      = w;
    new_entry.addr      = regAddress_i;
    new_entry.cr0_valid = recordCR0_i;
    if (recordCR0_i) new_entry.cr0 = {lt, gt, eq, so_new};
  end

  always_comb begin
    xer_next = xer_q;
    if (xerWrite_i) begin
      xer_next           = '0;
      xer_next[XER_SO]   = xerData_i[XER_SO];
      xer_next[XER_OV]   = xerData_i[XER_OV];
      xer_next[XER_CA]   = xerData_i[XER_CA];
      xer_next[XER_OV32] = xerData_i[XER_OV32];
      xer_next[XER_CA32] = xerData_i[XER_CA32];
    end else if (push) begin
      if (updateCA_i) begin
        xer_next[XER_CA]   = ca_new;
        xer_next[XER_CA32] = carry32_i;
      end
      if (updateOV_i) begin
        xer_next[XER_OV]   = ov_new;
        xer_next[XER_OV32] = ov32_new;
        xer_next[XER_SO]   = so_new;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      // NOTE: the two buffer entries are reset because the head drives the
      // outputs directly and must read as zero out of reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      xer_q  <= '0;
    end else begin
      xer_q <= xer_next;
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign wbValid_o   = ~empty;
  assign wbData_o    = head.data;
  assign wbAddress_o = head.addr;
  assign cr0Valid_o  = ~empty & head.cr0_valid;
  assign cr0_o       = head.cr0;
  assign xer_o       = xer_q;

endmodule
